// File: rtl/adc_serial_emu_pkg.sv
// Shared constants and types for the serial SAR ADC emulator.
// Optional build macro: NOISE_EN (adds a frame-rate LFSR dither source).
package adc_serial_emu_pkg;

  localparam int ADC_RES        = 12;
  localparam int ADC_CH         = 8;
  localparam int ADC_PORTS      = 2;
  localparam int ADC_FRAME_BITS = 16;
  localparam int ADC_LEAD_ZEROS = 2;

  typedef logic [ADC_RES-1:0] adc_code_t;

  typedef struct packed {
    logic rng;
    logic sgl;
  } adc_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } adc_state_t;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting towards the LSB
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] n;
    if (s[0]) n = {1'b0, s[15:1]} ^ LFSR_TAPS;
    else      n = {1'b0, s[15:1]};
    return n;
  endfunction

endpackage

// File: rtl/adc_emu_port.sv
// One emulated ADC output port: channel select, range halving, optional
// dither, pseudo-differential saturation and the per-frame hold register.
// Optional build macro: NOISE_EN (adds the dith input).
module adc_emu_port
  import adc_serial_emu_pkg::*;
#(
  parameter int N_CH = ADC_CH,
  parameter int RES  = ADC_RES,
  parameter int AW   = $clog2(N_CH)
) (
  input  logic                clk_16m,
  input  logic                rst_n,
`ifdef NOISE_EN
  input  logic [1:0]          dith,
`endif
  input  logic [N_CH*RES-1:0] din,
  input  logic [AW-1:0]       addr,
  input  adc_mode_t           mode,
  input  logic                capture,
  output logic [RES-1:0]      code,
  output logic [RES-1:0]      hold
);

  logic [AW-1:0]  pair_s;
  logic [RES-1:0] v_sel_s;
  logic [RES-1:0] v_even_s;
  logic [RES-1:0] v_odd_s;
  logic [RES:0]   diff_s;

  // Range halving of one raw channel code
  function automatic logic [RES-1:0] range_val(input logic [RES-1:0] raw, input logic rng);
    logic [RES-1:0] r;
    if (rng) r = {1'b0, raw[RES-1:1]};
    else     r = raw;
    return r;
  endfunction

`ifdef NOISE_EN
  // -1/0/0/+1 LSB dither, clamped to the unsigned code range
  function automatic logic [RES-1:0] dither(input logic [RES-1:0] v, input logic [1:0] d);
    logic [RES-1:0] r;
    case (d)
      2'b00:   r = (v == {RES{1'b0}}) ? v : v - {{(RES-1){1'b0}}, 1'b1};
      2'b11:   r = (v == {RES{1'b1}}) ? v : v + {{(RES-1){1'b0}}, 1'b1};
      default: r = v;
    endcase
    return r;
  endfunction
`endif

  // Code selection: single-ended pass-through or saturated pair difference
  always_comb begin
    pair_s    = addr;
    pair_s[0] = 1'b0;
    v_sel_s   = range_val(din[int'(addr) * RES +: RES], mode.rng);
    v_even_s  = range_val(din[int'(pair_s) * RES +: RES], mode.rng);
    v_odd_s   = range_val(din[(int'(pair_s) + 1) * RES +: RES], mode.rng);
`ifdef NOISE_EN
    v_sel_s   = dither(v_sel_s, dith);
    v_even_s  = dither(v_even_s, dith);
    v_odd_s   = dither(v_odd_s, dith);
`endif
    diff_s    = {1'b0, v_even_s} - {1'b0, v_odd_s};
    if (mode.sgl) begin
      code = v_sel_s;
    end else if (diff_s[RES] != diff_s[RES-1]) begin
      // the two top bits disagree: the difference left the signed RES-bit range
      code = diff_s[RES] ? {1'b1, {(RES-1){1'b0}}} : {1'b0, {(RES-1){1'b1}}};
    end else begin
      code = diff_s[RES-1:0];
    end
  end

  // Snapshot of the code at frame start; later din changes are ignored
  always_ff @(posedge clk_16m or negedge rst_n) begin
    if (!rst_n)       hold <= {RES{1'b0}};
    else if (capture) hold <= code;
    else              hold <= hold;
  end

endmodule

// File: rtl/adc_serial_emu.sv
// Multi-port serial SAR current-sense ADC emulator: frame FSM, bit
// sequencing, frame counter and abort flag.
// Optional build macro: NOISE_EN (per-frame LFSR dither on every port).
module adc_serial_emu
  import adc_serial_emu_pkg::*;
#(
  parameter int N_CH       = ADC_CH,
  parameter int RES        = ADC_RES,
  parameter int N_PORTS    = ADC_PORTS,
  parameter int LEAD_ZEROS = ADC_LEAD_ZEROS,
  parameter int FRAME_BITS = ADC_FRAME_BITS
) (
  input  logic                        clk_16m,
  input  logic                        rst_n,
  input  logic [N_PORTS*N_CH*RES-1:0] din,
  input  logic                        sclk_en,
  input  logic                        ncs,
  input  logic [$clog2(N_CH)-1:0]     addr,
  input  logic                        rng,
  input  logic                        sgl,
  output logic [N_PORTS-1:0]          dout,
  output logic                        frame_done,
  output logic                        abort_flag,
  output logic [15:0]                 frame_cnt,
  input  logic                        clr_flags
);

  localparam int                IDX_W    = $clog2(FRAME_BITS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_BITS - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

  adc_state_t                      state_r, state_s;
  logic [IDX_W-1:0]                bit_idx_r, bit_idx_s;
  logic                            ncs_q_r;
  logic [N_PORTS-1:0]              dout_r, dout_s;
  logic                            frame_done_r, frame_done_s;
  logic                            abort_flag_r, abort_flag_s;
  logic [15:0]                     frame_cnt_r, frame_cnt_s;
  logic                            capture_s;
  adc_mode_t                       mode_s;
  logic [N_PORTS-1:0][RES-1:0]     code_s;
  logic [N_PORTS-1:0][RES-1:0]     hold_s;

  assign mode_s     = '{rng: rng, sgl: sgl};
  assign dout       = dout_r;
  assign frame_done = frame_done_r;
  assign abort_flag = abort_flag_r;
  assign frame_cnt  = frame_cnt_r;

  // Serial bit at a frame position: leading zeros, code MSB first, trailing zeros
  function automatic logic bit_at(input logic [RES-1:0] code, input int idx);
    logic b;
    if ((idx >= LEAD_ZEROS) && (idx < LEAD_ZEROS + RES)) b = code[RES - 1 - (idx - LEAD_ZEROS)];
    else                                                 b = 1'b0;
    return b;
  endfunction

`ifdef NOISE_EN
  logic [15:0] lfsr_r;

  // Dither source advances once at every frame start
  always_ff @(posedge clk_16m or negedge rst_n) begin
    if (!rst_n)         lfsr_r <= LFSR_SEED;
    else if (capture_s) lfsr_r <= lfsr_step(lfsr_r);
    else                lfsr_r <= lfsr_r;
  end
`endif

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    adc_emu_port #(
      .N_CH (N_CH),
      .RES  (RES)
    ) u_port (
      .clk_16m (clk_16m),
      .rst_n   (rst_n),
`ifdef NOISE_EN
      .dith    (lfsr_r[(2 * p) % 16 +: 2]),
`endif
      .din     (din[p * N_CH * RES +: N_CH * RES]),
      .addr    (addr),
      .mode    (mode_s),
      .capture (capture_s),
      .code    (code_s[p]),
      .hold    (hold_s[p])
    );
  end

  // Next-state, next-bit and flag/counter update; events override clr_flags
  always_comb begin
    state_s      = state_r;
    bit_idx_s    = bit_idx_r;
    dout_s       = {N_PORTS{1'b0}};
    frame_done_s = 1'b0;
    capture_s    = 1'b0;
    abort_flag_s = clr_flags ? 1'b0 : abort_flag_r;
    frame_cnt_s  = clr_flags ? 16'h0000 : frame_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (!ncs && ncs_q_r) begin
          state_s   = ST_SHIFT;
          bit_idx_s = {IDX_W{1'b0}};
          capture_s = 1'b1;
          for (int p = 0; p < N_PORTS; p++) dout_s[p] = bit_at(code_s[p], 0);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (ncs) begin
          state_s      = ST_IDLE;
          abort_flag_s = 1'b1;
        end else if (sclk_en) begin
          if (bit_idx_r == LAST_IDX) begin
            state_s      = ST_DONE;
            frame_done_s = 1'b1;
            frame_cnt_s  = frame_cnt_s + 16'h0001;
          end else begin
            bit_idx_s = bit_idx_r + IDX_ONE;
            for (int p = 0; p < N_PORTS; p++) dout_s[p] = bit_at(hold_s[p], int'(bit_idx_s));
          end
        end else begin
          dout_s = dout_r;
        end
      end
      ST_DONE: begin
        if (ncs) state_s = ST_IDLE;
        else     state_s = ST_DONE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_16m or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      bit_idx_r    <= {IDX_W{1'b0}};
      ncs_q_r      <= 1'b1;
      dout_r       <= {N_PORTS{1'b0}};
      frame_done_r <= 1'b0;
      abort_flag_r <= 1'b0;
      frame_cnt_r  <= 16'h0000;
    end else begin
      state_r      <= state_s;
      bit_idx_r    <= bit_idx_s;
      ncs_q_r      <= ncs;
      dout_r       <= dout_s;
      frame_done_r <= frame_done_s;
      abort_flag_r <= abort_flag_s;
      frame_cnt_r  <= frame_cnt_s;
    end
  end

endmodule

// File: tb/tb_adc_serial_emu.sv
// Scoreboard bench for adc_serial_emu (default parameters, 2 ports).
// With NOISE_EN defined an extra dither-bound section runs.
module tb_adc_serial_emu;

  localparam int N_CH = 8;
  localparam int RES  = 12;
  localparam int NP   = 2;
  localparam int FB   = 16;
  localparam int LZ   = 2;

  logic                   clk_16m = 1'b0;
  logic                   rst_n;
  logic [NP*N_CH*RES-1:0] din;
  logic                   sclk_en;
  logic                   ncs;
  logic [2:0]             addr;
  logic                   rng;
  logic                   sgl;
  logic [NP-1:0]          dout;
  logic                   frame_done;
  logic                   abort_flag;
  logic [15:0]            frame_cnt;
  logic                   clr_flags;

  int                     n_cmp = 0;
  int                     n_err = 0;
  logic [NP-1:0]          sb_q[$];
  logic [NP-1:0]          last_exp;

  adc_serial_emu dut (
    .clk_16m    (clk_16m),
    .rst_n      (rst_n),
    .din        (din),
    .sclk_en    (sclk_en),
    .ncs        (ncs),
    .addr       (addr),
    .rng        (rng),
    .sgl        (sgl),
    .dout       (dout),
    .frame_done (frame_done),
    .abort_flag (abort_flag),
    .frame_cnt  (frame_cnt),
    .clr_flags  (clr_flags)
  );

  always #5 clk_16m = ~clk_16m;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int chan(input int p, input int c);
    int v;
    v = int'(din[(p * N_CH + c) * RES +: RES]);
    if (rng) v = v / 2;
    return v;
  endfunction

  // Reference code for one port from the current bench inputs
  function automatic logic [RES-1:0] model_code(input int p);
    int d;
    int c0;
    logic [31:0] r;
    if (sgl) begin
      d = chan(p, int'(addr));
    end else begin
      c0 = (int'(addr) / 2) * 2;
      d  = chan(p, c0) - chan(p, c0 + 1);
      if (d > 2047)  d = 2047;
      if (d < -2048) d = -2048;
    end
    r = d;
    return r[RES-1:0];
  endfunction

  task automatic push_expected();
    logic [RES-1:0] c [NP];
    logic [NP-1:0]  v;
    for (int p = 0; p < NP; p++) c[p] = model_code(p);
    for (int i = 0; i < FB; i++) begin
      for (int p = 0; p < NP; p++) begin
        if (i >= LZ && i < LZ + RES) v[p] = c[p][RES - 1 - (i - LZ)];
        else                         v[p] = 1'b0;
      end
      sb_q.push_back(v);
    end
  endtask

  task automatic pop_check(input string tag);
    if (sb_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      last_exp = sb_q.pop_front();
      check_eq(tag, {30'd0, dout}, {30'd0, last_exp});
    end
  endtask

  // Called at a negedge with inputs set up; lowers ncs to start the frame
  task automatic frame_start();
    push_expected();
    ncs = 1'b0;
    sclk_en = 1'b0;
    @(negedge clk_16m);
    pop_check("bit0");
    check_eq("no_done_start", {31'd0, frame_done}, 32'd0);
  endtask

  task automatic strobe_bit();
    sclk_en = 1'b1;
    @(negedge clk_16m);
    sclk_en = 1'b0;
    pop_check("bit");
  endtask

  task automatic hold_cycle();
    sclk_en = 1'b0;
    @(negedge clk_16m);
    check_eq("hold", {30'd0, dout}, {30'd0, last_exp});
  endtask

  task automatic frame_end(input logic [15:0] exp_cnt, input logic clr);
    sclk_en   = 1'b1;
    clr_flags = clr;
    @(negedge clk_16m);
    clr_flags = 1'b0;
    check_eq("end_dout", {30'd0, dout}, 32'd0);
    check_eq("done_pulse", {31'd0, frame_done}, 32'd1);
    check_eq("frame_cnt", {16'd0, frame_cnt}, {16'd0, exp_cnt});
    // still strobing in DONE: nothing may move
    @(negedge clk_16m);
    check_eq("done_once", {31'd0, frame_done}, 32'd0);
    check_eq("done_dout", {30'd0, dout}, 32'd0);
    ncs     = 1'b1;
    sclk_en = 1'b0;
    @(negedge clk_16m);
    check_eq("idle_dout", {30'd0, dout}, 32'd0);
  endtask

  task automatic full_frame(input logic [15:0] exp_cnt, input logic clr);
    frame_start();
    for (int i = 1; i < FB; i++) strobe_bit();
    frame_end(exp_cnt, clr);
  endtask

  task automatic rand_din();
    for (int i = 0; i < NP * N_CH; i++) din[i * RES +: RES] = RES'($urandom_range(0, 4095));
  endtask

  task automatic set_ch(input int p, input int c, input int v);
    din[(p * N_CH + c) * RES +: RES] = RES'(v);
  endtask

  initial begin
    rst_n = 1'b0; ncs = 1'b1; sclk_en = 1'b0; clr_flags = 1'b0;
    addr = 3'd0; rng = 1'b0; sgl = 1'b1; din = '0;
    rand_din();
    #12;
    check_eq("rst_dout", {30'd0, dout}, 32'd0);
    check_eq("rst_done", {31'd0, frame_done}, 32'd0);
    check_eq("rst_abort", {31'd0, abort_flag}, 32'd0);
    check_eq("rst_cnt", {16'd0, frame_cnt}, 32'd0);
    @(negedge clk_16m);
    rst_n = 1'b1;
    @(negedge clk_16m);

    // single-ended, full range, then half range
    set_ch(0, 2, 3360); set_ch(1, 2, 1234);
    addr = 3'd2; sgl = 1'b1; rng = 1'b0;
    full_frame(16'd1, 1'b0);
    rng = 1'b1;
    frame_start();
    for (int i = 1; i < 6; i++) strobe_bit();
    hold_cycle();
    for (int i = 6; i < FB; i++) strobe_bit();
    frame_end(16'd2, 1'b0);

    // pseudo-differential: plain, positive and negative saturation
    rng = 1'b0; sgl = 1'b0;
    set_ch(0, 2, 100);  set_ch(0, 3, 300);  set_ch(1, 2, 77);   set_ch(1, 3, 5);
    full_frame(16'd3, 1'b0);
    set_ch(0, 2, 4095); set_ch(0, 3, 0);    set_ch(1, 2, 0);    set_ch(1, 3, 4095);
    full_frame(16'd4, 1'b0);
    addr = 3'd7; rand_din();
    full_frame(16'd5, 1'b0);

    // abort after 7 strobes, then a normal frame, then clear
    addr = 3'd5; sgl = 1'b1; rand_din();
    frame_start();
    for (int i = 0; i < 7; i++) strobe_bit();
    ncs = 1'b1;
    @(negedge clk_16m);
    check_eq("abort_set", {31'd0, abort_flag}, 32'd1);
    check_eq("abort_dout", {30'd0, dout}, 32'd0);
    check_eq("abort_nodone", {31'd0, frame_done}, 32'd0);
    check_eq("abort_cnt", {16'd0, frame_cnt}, 32'd5);
    sb_q.delete();
    @(negedge clk_16m);
    full_frame(16'd6, 1'b0);
    check_eq("abort_sticky", {31'd0, abort_flag}, 32'd1);
    clr_flags = 1'b1;
    @(negedge clk_16m);
    clr_flags = 1'b0;
    check_eq("clr_abort", {31'd0, abort_flag}, 32'd0);
    check_eq("clr_cnt", {16'd0, frame_cnt}, 32'd0);

    // din changes after capture must not reach the serial stream
    addr = 3'd1; sgl = 1'b0; rand_din();
    frame_start();
    for (int i = 1; i < 4; i++) strobe_bit();
    rand_din(); addr = 3'd6; sgl = 1'b1; rng = 1'b1;
    for (int i = 4; i < FB; i++) strobe_bit();
    frame_end(16'd1, 1'b0);

    // counter wrap and clear coincident with completion
    force dut.frame_cnt_r = 16'hFFFF;
    #1;
    release dut.frame_cnt_r;
    @(negedge clk_16m);
    check_eq("preset_cnt", {16'd0, frame_cnt}, 32'h0000FFFF);
    full_frame(16'h0000, 1'b0);
    full_frame(16'h0001, 1'b0);
    full_frame(16'h0001, 1'b1);

    // asynchronous reset mid-frame at idx 9
    sgl = 1'b1; rng = 1'b0; addr = 3'd3; set_ch(0, 3, 4095); set_ch(1, 3, 4095);
    frame_start();
    for (int i = 1; i < 10; i++) strobe_bit();
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_dout", {30'd0, dout}, 32'd0);
    check_eq("mid_rst_cnt", {16'd0, frame_cnt}, 32'd0);
    check_eq("mid_rst_abort", {31'd0, abort_flag}, 32'd0);
    check_eq("mid_rst_done", {31'd0, frame_done}, 32'd0);
    sb_q.delete();
    ncs = 1'b1;
    @(negedge clk_16m);
    rst_n = 1'b1;
    @(negedge clk_16m);
    rand_din();
    full_frame(16'd1, 1'b0);

`ifdef NOISE_EN
    // constant mid-scale input: dither may move the code by at most one LSB
    for (int c = 0; c < NP * N_CH; c++) din[c * RES +: RES] = 12'd2048;
    sgl = 1'b1; rng = 1'b0; addr = 3'd4;
    for (int f = 0; f < 1000; f++) begin
      logic [RES-1:0] got [NP];
      for (int p = 0; p < NP; p++) got[p] = '0;
      ncs = 1'b0;
      for (int i = 0; i < FB; i++) begin
        sclk_en = (i != 0);
        @(negedge clk_16m);
        if (i >= LZ && i < LZ + RES)
          for (int p = 0; p < NP; p++) got[p] = {got[p][RES-2:0], dout[p]};
      end
      sclk_en = 1'b1;
      @(negedge clk_16m);
      ncs = 1'b1; sclk_en = 1'b0;
      @(negedge clk_16m);
      for (int p = 0; p < NP; p++)
        check_eq("noise_range", {31'd0, (got[p] >= 12'd2047) && (got[p] <= 12'd2049)}, 32'd1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adc_serial_emu.md
Name: adc_serial_emu

Overview:
- Synthesisable, parametrised emulator of a dual-port serial SAR current-sense ADC.
- Replaces the behavioural single-configuration ADC model for calibrator / adc_current_if benches and for hardware-in-loop bring-up without the real ADC fitted.
- Generalises the previous model in four ways:
  - channel count, resolution, frame length and port count are parameters;
  - pseudo-differential mode with saturation;
  - range halving;
  - frame-abort detection and frame statistics.

Parameters:
- N_CH, 8, analog channels per port (power of 2, ≥2)
- RES, 12, conversion resolution in bits
- N_PORTS, 2, parallel serial outputs (A, B, ...)
- LEAD_ZEROS, 2, zero bits before the MSB
- FRAME_BITS, 16, total SCLK periods per frame (≥ LEAD_ZEROS+RES)

Ports:
- clock  input  1  system clock (16 MHz domain)
- reset  input  1  asynchronous, active-low reset
- din  input  N_PORTS*N_CH*RES  flattened channel codes, port-major, channel-minor
- sclk_en  input  1  serial bit-advance strobe, synchronous to clock
- ncs  input  1  active-low chip select / convert start
- addr  input  $clog2(N_CH)  channel select
- rng  input  1  1 = 2×Vref range (code halved)
- sgl  input  1  1 = single-ended, 0 = pseudo-differential
- dout  output  N_PORTS  serial data, MSB first
- frame_done  output  1  one-cycle pulse on a complete frame
- abort_flag  output  1  sticky; ncs rose mid-frame
- frame_cnt  output  16  completed-frame counter
- clr_flags  input  1  synchronous clear of abort_flag and frame_cnt

Behaviour:
- Reset values: dout=0, frame_done=0, abort_flag=0, frame_cnt=0, state IDLE.
- States: IDLE, SHIFT, DONE.
- IDLE → SHIFT:
  - Trigger: first clock edge with ncs=0, registered ncs_q=1.
  - On that edge, capture addr, rng, sgl, and snapshot a code per port into a hold register.
  - Set bit_idx=0 and drive dout = bit 0.
  - din changes after capture do not affect the frame.
- Code per port:
  - v(c) = rng ? din[c]>>1 : din[c].
  - sgl=1: code = v(addr), straight binary.
  - sgl=0: code = v({addr[msb:1],0}) − v({addr[msb:1],1}), computed in RES+1 bits, saturated to signed RES-bit (max 2^(RES-1)−1, min −2^(RES-1)), emitted two's complement.
- Bit order:
  - idx 0..LEAD_ZEROS−1 → 0;
  - next RES bits → code MSB first;
  - remainder up to FRAME_BITS−1 → 0.
- SHIFT:
  - Each clock with sclk_en=1 and ncs=0: bit_idx++, dout presents the new bit (one-clock latency from strobe).
  - sclk_en=0 holds dout.
  - Edge that advances past idx FRAME_BITS−1 → DONE, dout=0, frame_done=1 for that one cycle, frame_cnt++ (wraps FFFF→0000).
- DONE: dout=0. Further sclk_en is ignored. ncs=1 → IDLE.
- ncs=1 in SHIFT (any idx): → IDLE, dout=0, abort_flag=1, no frame_done, frame_cnt unchanged.
- IDLE with ncs=1: dout=0.
- clr_flags coincident with a new abort or frame completion: the event wins (abort_flag=1 / frame_cnt=1).
- Asserting reset mid-frame returns immediately to reset values. The frame is not counted or flagged.

Optional Feature:
- Macro NOISE_EN.
- When defined:
  - a 16-bit Galois LFSR (poly x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset) advances once per frame start;
  - its two LSBs add −1/0/0/+1 LSB dither per port to v(c) before the sgl processing, saturating at 0 and 2^RES−1;
  - ports use rotated LFSR bits (port p uses bits 2p+1:2p).
- When undefined: no LFSR logic; output is deterministic.

Decomposition:
- Shared package (PFS): ADC_RES, ADC_CH, ADC_FRAME_BITS, ADC_LEAD_ZEROS constants; typedef adc_code_t (logic [RES-1:0]); typedef adc_mode_t struct {rng, sgl}.
- One sub-module, adc_emu_port:
  - per-port code select, range, differential saturation and hold register;
  - instantiated N_PORTS times under a generate loop.
- The FSM, counters and flags stay in the top.

Test Plan:
1. Port A ch2=3360, sgl=1, rng=0, addr=2, 16 strobes → douta stream 00_1101_0010_0000_00; frame_done pulses once; frame_cnt=1.
2. Same stimulus with rng=1 → code 1680 (0x690), stream 00_0110_1001_0000_00.
3. sgl=0, addr=2, ch2=100, ch3=300 → 0xF38 (−200). ch2=4095, ch3=0 → saturates to 0x7FF.
4. ncs raised after 7 strobes → abort_flag=1, no frame_done, frame_cnt unchanged. Next full frame completes normally.
5. din changed mid-frame; frame_cnt preset to FFFF via 65535 frames (or forced) → serial data reflects the captured value only; wraps to 0000; clr_flags with a simultaneous completion → frame_cnt=1.
6. reset asserted at idx 9 → all outputs 0 immediately. With NOISE_EN, 1000 frames of constant 2048 stay within 2047..2049.
